// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the coherence bus data port and two
// instruction-fetch ports. Data wins by default, fetches alternate between cores.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2,
  parameter bit          ERR_RETRY    = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             bus_dREN,
  input  logic             bus_dWEN,
  input  logic [31:0]      bus_daddr,
  input  logic [31:0]      bus_dstore,
  output logic             bus_dwait,
  output logic [31:0]      bus_dload,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} ArbState;

  localparam logic [1:0]    RAM_ACCESS = 2'b10;
  localparam logic [1:0]    RAM_ERROR  = 2'b11;
  localparam int unsigned   CW         = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);

  ArbState       r_state;
  logic          r_igrantId;
  logic          r_lastIcore;
  logic [CW-1:0] r_starveCnt;

  ArbState       w_stateNext;
  logic          w_igrantIdNext;
  logic          w_lastIcoreNext;
  logic [CW-1:0] w_starveCntNext;

  logic          w_dReq;
  logic          w_iReq;
  logic          w_starveHold;
  logic          w_ramDone;
  logic          w_ramRetry;
  logic [31:0]   w_loadData;
  logic [CW-1:0] w_starveInc;
  logic          w_pickId;

  assign w_dReq       = bus_dREN | bus_dWEN;
  assign w_iReq       = |iREN;
  assign w_starveHold = (STARVE_LIMIT != 0) && (r_starveCnt == LIMIT) && w_iReq;
  // Without retry an ERROR completes the transfer, but its data is never handed on.
  assign w_ramDone    = (ramstate == RAM_ACCESS) || (!ERR_RETRY && (ramstate == RAM_ERROR));
  assign w_ramRetry   = ERR_RETRY && (ramstate == RAM_ERROR);
  assign w_loadData   = (ramstate == RAM_ERROR) ? 32'h0 : ramload;
  assign w_starveInc  = (r_starveCnt == LIMIT) ? r_starveCnt : r_starveCnt + CW'(1);
  assign w_pickId     = (iREN == 2'b11) ? ~r_lastIcore : iREN[1];

  always_comb begin
    w_stateNext     = r_state;
    w_igrantIdNext  = r_igrantId;
    w_lastIcoreNext = r_lastIcore;
    w_starveCntNext = r_starveCnt;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = 32'h0;
    ramstore        = 32'h0;
    bus_dwait       = 1'b1;
    bus_dload       = 32'h0;
    iwait           = 2'b11;
    iload           = '0;

    case (r_state)
      IDLE: begin
        if (w_dReq && !w_starveHold) begin
          w_stateNext = DGRANT;
        end else if (w_iReq) begin
          w_stateNext    = IGRANT;
          w_igrantIdNext = w_pickId;
        end
      end

      DGRANT: begin
        ramWEN   = bus_dWEN;
        ramREN   = bus_dREN & ~bus_dWEN;
        ramaddr  = bus_daddr;
        ramstore = bus_dstore;
        if (w_ramDone) begin
          bus_dwait       = 1'b0;
          bus_dload       = w_loadData;
          w_stateNext     = IDLE;
          w_starveCntNext = w_iReq ? w_starveInc : '0;
        end else if (w_ramRetry || !w_dReq) begin
          w_stateNext = IDLE;
        end
      end

      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_igrantId];
        if (w_ramDone) begin
          iwait[r_igrantId] = 1'b0;
          iload[r_igrantId] = w_loadData;
          w_lastIcoreNext   = r_igrantId;
          w_starveCntNext   = '0;
          w_stateNext       = IDLE;
        end else if (w_ramRetry || !iREN[r_igrantId]) begin
          w_stateNext = IDLE;
        end
      end

      default: w_stateNext = IDLE;
    endcase
  end

  // Reset drops the grant at once, so the RAM enables fall without waiting for a clock.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_igrantId  <= 1'b0;
      r_lastIcore <= 1'b1;
      r_starveCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_igrantId  <= w_igrantIdNext;
      r_lastIcore <= w_lastIcoreNext;
      r_starveCnt <= w_starveCntNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed arbitration scenarios, then random traffic against a RAM model,
// a transaction-level memory scoreboard and the starvation / round-robin rules.
module tb_mem_arbiter;

  localparam int         STARVE_LIMIT = 2;
  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             bus_dREN, bus_dWEN;
  logic [31:0]      bus_daddr, bus_dstore;
  logic             bus_dwait;
  logic [31:0]      bus_dload;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ramMem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  bit          forceOn;
  logic [1:0]  forceState;
  int          ramLat, ramBusyCnt, latMax, errPct;

  logic        dren, dwen;
  logic [31:0] da, ds;
  logic [1:0]  ir;
  logic [31:0] ia [2];
  int          dAge, maxAge, lows, starveRun, rrCore;
  int          iAge [2];
  bit          rrValid;
  int          got [$];
  int          expOrder [6] = '{1, 1, 2, 1, 1, 2};

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ERR_RETRY(1'b1)) dut (
    .CLK(CLK), .nRST(nRST),
    .bus_dREN(bus_dREN), .bus_dWEN(bus_dWEN), .bus_daddr(bus_daddr), .bus_dstore(bus_dstore),
    .bus_dwait(bus_dwait), .bus_dload(bus_dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  function automatic logic [31:0] refRd(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : 32'h0;
  endfunction

  // RAM model: random BUSY latency, optional ERROR injection, or a forced state.
  task automatic ramRespond();
    logic [1:0] st;
    if (!(ramREN || ramWEN)) begin
      st = FREE;
      ramBusyCnt = 0;
    end else if (ramBusyCnt < ramLat) begin
      st = BUSY;
      ramBusyCnt++;
    end else if (int'($urandom_range(99)) < errPct) begin
      st = ERROR;
      ramBusyCnt = 0;
    end else begin
      st = ACCESS;
      ramBusyCnt = 0;
      ramLat = int'($urandom_range(latMax));
    end
    if (forceOn) st = forceState;
    ramload = $urandom;
    if (st == ACCESS && ramREN) ramload = ramMem.exists(ramaddr) ? ramMem[ramaddr] : 32'h0;
    if (st == ACCESS && ramWEN) ramMem[ramaddr] = ramstore;
    ramstate = st;
  endtask

  task automatic applyStimulus(input logic rEn, input logic wEn, input logic [31:0] addr,
                               input logic [31:0] store, input logic [1:0] iEn,
                               input logic [31:0] ia0, input logic [31:0] ia1);
    @(negedge CLK);
    bus_dREN   = rEn;
    bus_dWEN   = wEn;
    bus_daddr  = addr;
    bus_dstore = store;
    iREN       = iEn;
    iaddr[0]   = ia0;
    iaddr[1]   = ia1;
    #1;
    ramRespond();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    bus_dREN = 1'b0; bus_dWEN = 1'b0; bus_daddr = 32'h0; bus_dstore = 32'h0;
    iREN = 2'b00; iaddr = '0; ramstate = FREE; ramload = 32'h0;
    forceOn = 1'b0; forceState = FREE; ramLat = 0; latMax = 0; errPct = 0; ramBusyCnt = 0;
    ramMem[32'h0]  = 32'h1111_1111;
    ramMem[32'h40] = 32'h2222_2222;

    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rst_ramREN", 32'(ramREN), 32'd0);
    checkOutput("rst_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("rst_dwait", 32'(bus_dwait), 32'd1);
    checkOutput("rst_iwait", 32'(iwait), 32'd3);
    nRST = 1'b1;

    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("idle_ramaddr", ramaddr, 32'h0);

    // Data write then read-back of the same word.
    applyStimulus(0, 1, 32'h100, 32'hDEADBEEF, 2'b00, 0, 0);
    checkOutput("t1_idleWEN", 32'(ramWEN), 32'd0);
    checkOutput("t1_idleDwait", 32'(bus_dwait), 32'd1);
    applyStimulus(0, 1, 32'h100, 32'hDEADBEEF, 2'b00, 0, 0);
    checkOutput("t1_wen", 32'(ramWEN), 32'd1);
    checkOutput("t1_ren", 32'(ramREN), 32'd0);
    checkOutput("t1_waddr", ramaddr, 32'h100);
    checkOutput("t1_wdata", ramstore, 32'hDEADBEEF);
    checkOutput("t1_wdone", 32'(bus_dwait), 32'd0);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("t1_bubble", 32'(bus_dwait), 32'd1);
    applyStimulus(1, 0, 32'h100, 0, 2'b00, 0, 0);
    checkOutput("t1_rdIdle", 32'(ramREN), 32'd0);
    applyStimulus(1, 0, 32'h100, 0, 2'b00, 0, 0);
    checkOutput("t1_rdREN", 32'(ramREN), 32'd1);
    checkOutput("t1_rdDone", 32'(bus_dwait), 32'd0);
    checkOutput("t1_rdData", bus_dload, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // Both cores fetch: core 0 first, then core 1 after the bubble.
    applyStimulus(0, 0, 0, 0, 2'b11, 32'h0, 32'h40);
    checkOutput("t2_c1", 32'(iwait), 32'd3);
    applyStimulus(0, 0, 0, 0, 2'b11, 32'h0, 32'h40);
    checkOutput("t2_c2wait", 32'(iwait), 32'd2);
    checkOutput("t2_c2addr", ramaddr, 32'h0);
    checkOutput("t2_c2load", iload[0], 32'h1111_1111);
    applyStimulus(0, 0, 0, 0, 2'b11, 32'h0, 32'h40);
    checkOutput("t2_c3", 32'(iwait), 32'd3);
    applyStimulus(0, 0, 0, 0, 2'b11, 32'h0, 32'h40);
    checkOutput("t2_c4wait", 32'(iwait), 32'd1);
    checkOutput("t2_c4load", iload[1], 32'h2222_2222);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // Data and core 0 held together: two data grants, then one fetch.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1, 0, 32'h200, 0, 2'b01, 32'h0, 32'h40);
      if (!bus_dwait) got.push_back(1);
      if (iwait != 2'b11) got.push_back(2);
    end
    checkOutput("t3_count", 32'(got.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("t3_grant%0d", k), (k < got.size()) ? 32'(got[k]) : 32'd0,
                  32'(expOrder[k]));
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // Data read aborted while the RAM is busy.
    applyStimulus(1, 0, 32'h300, 0, 2'b00, 0, 0);
    forceOn = 1'b1; forceState = BUSY;
    applyStimulus(1, 0, 32'h300, 0, 2'b00, 0, 0);
    checkOutput("t4_busyREN", 32'(ramREN), 32'd1);
    checkOutput("t4_busyDwait", 32'(bus_dwait), 32'd1);
    applyStimulus(0, 0, 32'h300, 0, 2'b00, 0, 0);
    checkOutput("t4_abortDwait", 32'(bus_dwait), 32'd1);
    forceOn = 1'b0;
    applyStimulus(1, 0, 32'h300, 0, 2'b00, 0, 0);
    checkOutput("t4_idleREN", 32'(ramREN), 32'd0);
    checkOutput("t4_idleDwait", 32'(bus_dwait), 32'd1);
    applyStimulus(1, 0, 32'h300, 0, 2'b00, 0, 0);
    checkOutput("t4_reissue", 32'(bus_dwait), 32'd0);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // Reset in the middle of a busy fetch.
    applyStimulus(0, 0, 0, 0, 2'b01, 32'h0, 32'h40);
    forceOn = 1'b1; forceState = BUSY;
    applyStimulus(0, 0, 0, 0, 2'b01, 32'h0, 32'h40);
    checkOutput("t5_busyREN", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    checkOutput("t5_asyncREN", 32'(ramREN), 32'd0);
    checkOutput("t5_rstIwait", 32'(iwait), 32'd3);
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    forceOn = 1'b0; ramBusyCnt = 0;
    applyStimulus(0, 0, 0, 0, 2'b11, 32'h0, 32'h40);
    checkOutput("t5_idleREN", 32'(ramREN), 32'd0);
    applyStimulus(0, 0, 0, 0, 2'b11, 32'h0, 32'h40);
    checkOutput("t5_core0First", 32'(iwait), 32'd2);
    checkOutput("t5_load", iload[0], 32'h1111_1111);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // One RAM error on a fetch, then a clean retry.
    applyStimulus(0, 0, 0, 0, 2'b10, 32'h0, 32'h40);
    forceOn = 1'b1; forceState = ERROR;
    applyStimulus(0, 0, 0, 0, 2'b10, 32'h0, 32'h40);
    checkOutput("t6_errREN", 32'(ramREN), 32'd1);
    checkOutput("t6_errIwait", 32'(iwait), 32'd3);
    forceOn = 1'b0;
    applyStimulus(0, 0, 0, 0, 2'b10, 32'h0, 32'h40);
    checkOutput("t6_rearbREN", 32'(ramREN), 32'd0);
    checkOutput("t6_rearbIwait", 32'(iwait), 32'd3);
    applyStimulus(0, 0, 0, 0, 2'b10, 32'h0, 32'h40);
    checkOutput("t6_retryIwait", 32'(iwait), 32'd1);
    checkOutput("t6_retryLoad", iload[1], 32'h2222_2222);
    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);

    // Random traffic: requests are held until their own completion.
    latMax = 2; errPct = 10; ramLat = 0; ramBusyCnt = 0;
    for (int a = 0; a < 8; a++) begin
      ds = $urandom;
      ramMem[32'h1000 + 32'(a * 4)] = ds;
      refMem[32'h1000 + 32'(a * 4)] = ds;
    end
    dren = 0; dwen = 0; da = 0; ds = 0; ir = 2'b00; ia[0] = 0; ia[1] = 0;
    dAge = 0; iAge[0] = 0; iAge[1] = 0; maxAge = 0; starveRun = 0; rrValid = 0; rrCore = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(dren || dwen) && $urandom_range(3) == 0) begin
        dwen = 1'($urandom_range(1));
        dren = 1'($urandom_range(1));
        if (!dwen) dren = 1'b1;
        da = 32'h1000 + ($urandom_range(7) << 2);
        ds = $urandom;
        dAge = 0;
      end
      for (int n = 0; n < 2; n++)
        if (!ir[n] && $urandom_range(2) == 0) begin
          ir[n] = 1'b1;
          ia[n] = 32'h1000 + ($urandom_range(7) << 2);
          iAge[n] = 0;
        end

      applyStimulus(dren, dwen, da, ds, ir, ia[0], ia[1]);

      lows = int'(!bus_dwait) + int'(!iwait[0]) + int'(!iwait[1]);
      checkOutput("rnd_oneWait", 32'(lows <= 1), 32'd1);
      checkOutput("rnd_doneOnAccess", 32'(lows != 0), 32'(ramstate == ACCESS));
      checkOutput("rnd_noRdWr", 32'(ramREN && ramWEN), 32'd0);
      if (ramWEN) begin
        checkOutput("rnd_waddr", ramaddr, da);
        checkOutput("rnd_wdata", ramstore, ds);
      end
      if (!bus_dwait) begin
        checkOutput("rnd_dreq", 32'(dren || dwen), 32'd1);
        if (dwen) refMem[da] = ds;
        else checkOutput("rnd_dload", bus_dload, refRd(da));
        if (ir != 2'b00) begin
          starveRun++;
          checkOutput("rnd_starve", 32'(starveRun <= STARVE_LIMIT), 32'd1);
        end else begin
          starveRun = 0;
        end
        dren = 1'b0;
        dwen = 1'b0;
      end else begin
        checkOutput("rnd_dloadIdle", bus_dload, 32'h0);
      end
      for (int n = 0; n < 2; n++) begin
        if (!iwait[n]) begin
          checkOutput("rnd_ireq", 32'(ir[n]), 32'd1);
          checkOutput("rnd_iload", iload[n], refRd(ia[n]));
          if (rrValid) checkOutput("rnd_roundRobin", 32'(n), 32'(rrCore));
          rrValid   = ir[1-n];
          rrCore    = 1 - n;
          starveRun = 0;
          ir[n]     = 1'b0;
        end else begin
          checkOutput("rnd_iloadIdle", iload[n], 32'h0);
        end
      end

      if (dren || dwen) dAge++;
      if (dAge > maxAge) maxAge = dAge;
      for (int n = 0; n < 2; n++) begin
        if (ir[n]) iAge[n]++;
        if (iAge[n] > maxAge) maxAge = iAge[n];
      end
    end
    checkOutput("rnd_maxAge", 32'(maxAge < 200), 32'd1);

    applyStimulus(0, 0, 0, 0, 2'b00, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
